// File: rtl/ram2e_phase_sync.sv
// ram2e_phase_sync: PHI1 phase tracker for the RAM2E DRAM controller.
// Samples PHI1 in the C14M domain and produces the 6502-cycle state counter S,
// a PHI1-rise strobe, a refresh-slot enable and a lock qualifier.
// Optional build macro RAM2E_PHI1_FILTER_EN adds a two-flop synchronizer and a
// 2-sample agreement filter in front of rise detection (3-edge extra latency).
module ram2e_phase_sync #(
    parameter int LOCK_COUNT = 3,
    parameter int REF_PERIOD = 13,
    parameter int NORM_LEN   = 14,
    parameter int LONG_LEN   = 16,
    parameter int TIMEOUT    = 31
) (
    input  logic       C14M,
    input  logic       nRST,
    input  logic       PHI1,
    output logic [3:0] S,
    output logic       PHI1R,
    output logic       LOCKED,
    output logic       REFEN,
    output logic       LONGCYC,
    output logic       PERR
);

    typedef enum logic [1:0] {HUNT, ACQ, LOCK} state_t;

    localparam logic [4:0] NORM_C   = 5'(NORM_LEN);
    localparam logic [4:0] LONG_C   = 5'(LONG_LEN);
    localparam logic [4:0] TO_C     = 5'(TIMEOUT);
    localparam logic [2:0] LOCK_C   = 3'(LOCK_COUNT);
    localparam logic [3:0] REF_LAST = 4'(REF_PERIOD - 1);

    state_t     state;
    logic       phi_lvl;
    logic       phi1s;
    logic       phi0seen;
    logic [4:0] c;
    logic [2:0] good_cnt;
    logic [3:0] ref_cnt;
    logic       rise;
    logic       good;
    logic       timeout;
    logic       leave;

`ifdef RAM2E_PHI1_FILTER_EN
    logic sync1, sync2, phi_flt;

    // Synchronize PHI1, then only move the filtered level once two
    // consecutive synchronized samples agree (swallows 1-tick glitches).
    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            phi_flt <= 1'b0;
        end else begin
            sync1 <= PHI1;
            sync2 <= sync1;
            if (sync1 == sync2) phi_flt <= sync2;
        end
    end

    assign phi_lvl = phi_flt;
`else
    assign phi_lvl = PHI1;
`endif

    // A rise needs a previously seen low level, so a bus that powers up high
    // (or comes back after a timeout while high) is not mistaken for a rise.
    assign rise    = phi_lvl & ~phi1s & phi0seen;
    assign good    = (c == NORM_C) || (c == LONG_C);
    assign timeout = (state != HUNT) && !rise && (c >= TO_C);
    assign leave   = LOCKED && (timeout || (rise && !good));

    // Input sampling, state counter S, period counter C and rise-side outputs.
    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            phi1s    <= 1'b0;
            phi0seen <= 1'b0;
            S        <= 4'd0;
            c        <= 5'd0;
            PHI1R    <= 1'b0;
            LONGCYC  <= 1'b0;
        end else begin
            phi1s <= phi_lvl;
            if (timeout)      phi0seen <= 1'b0;
            else if (!phi_lvl) phi0seen <= 1'b1;
            PHI1R <= rise;
            if (rise) begin
                S       <= 4'd1;
                c       <= 5'd1;
                LONGCYC <= (c == LONG_C);
            end else begin
                if (S != 4'd0 && S != 4'd15) S <= S + 4'd1;
                if (c != 5'd31)              c <= c + 5'd1;
            end
        end
    end

    // Lock FSM: judge each period at the rise, drop to HUNT on a dead bus.
    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            state    <= HUNT;
            good_cnt <= 3'd0;
            LOCKED   <= 1'b0;
            PERR     <= 1'b0;
        end else begin
            case (state)
                HUNT: begin
                    if (rise) begin
                        state    <= ACQ;
                        good_cnt <= 3'd0;
                    end
                end
                ACQ: begin
                    if (timeout) begin
                        state  <= HUNT;
                        LOCKED <= 1'b0;
                    end else if (rise) begin
                        if (!good) begin
                            good_cnt <= 3'd0;
                        end else if (good_cnt + 3'd1 == LOCK_C) begin
                            state    <= LOCK;
                            LOCKED   <= 1'b1;
                            good_cnt <= 3'd0;
                        end else begin
                            good_cnt <= good_cnt + 3'd1;
                        end
                    end
                end
                LOCK: begin
                    if (timeout) begin
                        state  <= HUNT;
                        LOCKED <= 1'b0;
                    end else if (rise && !good) begin
                        state    <= ACQ;
                        LOCKED   <= 1'b0;
                        good_cnt <= 3'd0;
                        PERR     <= 1'b1;
                    end
                end
                default: begin
                    state  <= HUNT;
                    LOCKED <= 1'b0;
                end
            endcase
        end
    end

    // Refresh slot: step once per locked 6502 cycle (the edge after S==1) and
    // hold REFEN for the whole cycle; restart the slot count on loss of lock.
    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            ref_cnt <= 4'd0;
            REFEN   <= 1'b0;
        end else if (leave) begin
            ref_cnt <= 4'd0;
            REFEN   <= 1'b0;
        end else if (LOCKED && S == 4'd1) begin
            REFEN   <= (ref_cnt == 4'd0);
            ref_cnt <= (ref_cnt == REF_LAST) ? 4'd0 : ref_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_ram2e_phase_sync.sv
// Bench for ram2e_phase_sync: per-rise expectations go into a scoreboard as
// each PHI1 cycle is driven and are checked when PHI1R pulses; per-scenario
// tasks check S, REFEN, LOCKED timing directly. Honors RAM2E_PHI1_FILTER_EN.
module tb_ram2e_phase_sync;

`ifdef RAM2E_PHI1_FILTER_EN
    localparam int LAG = 3;
`else
    localparam int LAG = 0;
`endif

    typedef struct packed {
        logic locked;
        logic longcyc;
        logic perr;
    } exp_t;

    logic       C14M = 1'b0;
    logic       nRST = 1'b0;
    logic       PHI1 = 1'b0;
    logic [3:0] S;
    logic       PHI1R, LOCKED, REFEN, LONGCYC, PERR;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];
    int   s_log[$];
    int   p_log[$];
    int   r_log[$];
    int   l_log[$];

    ram2e_phase_sync dut (
        .C14M   (C14M),
        .nRST   (nRST),
        .PHI1   (PHI1),
        .S      (S),
        .PHI1R  (PHI1R),
        .LOCKED (LOCKED),
        .REFEN  (REFEN),
        .LONGCYC(LONGCYC),
        .PERR   (PERR)
    );

    always #5 C14M = ~C14M;

    // Scoreboard side: every PHI1R pulse must match the oldest queued expectation.
    always @(negedge C14M) begin
        if (nRST && PHI1R) begin
            exp_t e;
            n_chk++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_rise: unexpected PHI1R pulse at %0t", $time);
            end else begin
                e = sb.pop_front();
                if ({LOCKED, LONGCYC, PERR, S} !== {e.locked, e.longcyc, e.perr, 4'd1}) begin
                    n_err++;
                    $display("FAIL sb_rise: at %0t got L/LC/PE/S=%b%b%b/%0d expected %b%b%b/1",
                             $time, LOCKED, LONGCYC, PERR, S, e.locked, e.longcyc, e.perr);
                end
            end
        end
    end

    task automatic push_exp(input logic l, input logic lc, input logic pe);
        exp_t e;
        e.locked = l; e.longcyc = lc; e.perr = pe;
        sb.push_back(e);
    endtask

    // One PHI1 period of len ticks, high for the first 'high' ticks, with an
    // optional 1-tick high glitch at index 'glitch'; logs outputs after each edge.
    task automatic phi_cycle(input int len, input int high, input int glitch);
        s_log.delete(); p_log.delete(); r_log.delete(); l_log.delete();
        for (int i = 0; i < len; i++) begin
            PHI1 = (i < high) || (i == glitch);
            @(posedge C14M);
            #1;
            s_log.push_back(int'(S));
            p_log.push_back(int'(PHI1R));
            r_log.push_back(int'(REFEN));
            l_log.push_back(int'(LOCKED));
        end
    endtask

    task automatic do_reset();
        PHI1 = 1'b0;
        nRST = 1'b0;
        repeat (3) @(posedge C14M);
        #1;
        nRST = 1'b1;
        phi_cycle(5, 0, -1);
    endtask

    // Reset plus three cycles; the next driven rise is the one that locks.
    task automatic acquire();
        do_reset();
        repeat (3) begin
            push_exp(0, 0, 0);
            phi_cycle(14, 7, -1);
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        PHI1 = 1'b1;
        repeat (2) @(posedge C14M);
        #1;
        n_chk++;
        if ({S, PHI1R, LOCKED, REFEN, LONGCYC, PERR} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_state: got S=%0d R=%b L=%b RE=%b LC=%b PE=%b expected all 0",
                     S, PHI1R, LOCKED, REFEN, LONGCYC, PERR);
        end
        PHI1 = 1'b0;
    endtask

    task automatic test_lock();
        acquire();
        repeat (3) begin
            push_exp(1, 0, 0);
            phi_cycle(14, 7, -1);
        end
        for (int i = 0; i < 14; i++) begin
            n_chk++;
            if (s_log[i] !== ((i - LAG + 14) % 14) + 1) begin
                n_err++;
                $display("FAIL lock_s_seq[%0d]: got %0d expected %0d", i, s_log[i], ((i - LAG + 14) % 14) + 1);
            end
            n_chk++;
            if (p_log[i] !== int'(i == LAG)) begin
                n_err++;
                $display("FAIL lock_phi1r[%0d]: got %0d expected %0d", i, p_log[i], int'(i == LAG));
            end
        end
    endtask

    task automatic test_long();
        acquire();
        push_exp(1, 0, 0); phi_cycle(14, 7, -1);
        push_exp(1, 0, 0); phi_cycle(16, 8, -1);
        push_exp(1, 1, 0); phi_cycle(14, 7, -1);
        push_exp(1, 0, 0); phi_cycle(14, 7, -1);
    endtask

    task automatic test_short();
        acquire();
        push_exp(1, 0, 0); phi_cycle(14, 7, -1);
        push_exp(1, 0, 0); phi_cycle(12, 6, -1);
        push_exp(0, 0, 1); phi_cycle(14, 7, -1);
        push_exp(0, 0, 1); phi_cycle(14, 7, -1);
        push_exp(0, 0, 1); phi_cycle(14, 7, -1);
        push_exp(1, 0, 1); phi_cycle(14, 7, -1);
        push_exp(1, 0, 1); phi_cycle(14, 7, -1);
    endtask

    task automatic test_refresh();
        int highs = 0;
        acquire();
        for (int k = 0; k < 26; k++) begin
            push_exp(1, 0, 0);
            phi_cycle(14, 7, -1);
            n_chk++;
            if (r_log[LAG + 3] !== int'(k % 13 == 0)) begin
                n_err++;
                $display("FAIL refen_cycle[%0d]: got %0d expected %0d", k, r_log[LAG + 3], int'(k % 13 == 0));
            end
            foreach (r_log[i]) highs += r_log[i];
        end
        n_chk++;
        if (highs !== 28) begin
            n_err++;
            $display("FAIL refen_total: got %0d ticks expected 28", highs);
        end
    endtask

    task automatic test_timeout();
        int s_end;
        acquire();
        push_exp(1, 0, 0); phi_cycle(14, 7, -1);
        s_end = s_log[13];
        phi_cycle(40, 0, -1);
        n_chk++;
        if (s_end !== 14 - LAG) begin
            n_err++;
            $display("FAIL to_s_count: got %0d expected %0d", s_end, 14 - LAG);
        end
        n_chk++;
        if (s_log[LAG] !== 15 || s_log[39] !== 15) begin
            n_err++;
            $display("FAIL to_s_sat: got %0d/%0d expected 15/15", s_log[LAG], s_log[39]);
        end
        n_chk++;
        if (l_log[16 + LAG] !== 1 || l_log[17 + LAG] !== 0) begin
            n_err++;
            $display("FAIL to_lock_drop: got %0d/%0d expected 1/0", l_log[16 + LAG], l_log[17 + LAG]);
        end
        n_chk++;
        if (PERR !== 1'b0) begin
            n_err++;
            $display("FAIL to_perr: got %b expected 0", PERR);
        end
        repeat (3) begin
            push_exp(0, 0, 0); phi_cycle(14, 7, -1);
        end
        push_exp(1, 0, 0); phi_cycle(14, 7, -1);
    endtask

    task automatic test_reset_mid();
        acquire();
        push_exp(1, 0, 0); phi_cycle(14, 7, -1);
        push_exp(1, 0, 0); phi_cycle(12, 6, -1);
        push_exp(0, 0, 1); phi_cycle(14, 7, -1);
        push_exp(0, 0, 1); phi_cycle(14, 7, -1);
        push_exp(0, 0, 1); phi_cycle(14, 7, -1);
        push_exp(1, 0, 1); phi_cycle(LAG + 7, 7, -1);
        n_chk++;
        if ({S, LOCKED, REFEN, PERR} !== {4'd7, 3'b111}) begin
            n_err++;
            $display("FAIL mid_pre: got S=%0d L=%b RE=%b PE=%b expected 7/1/1/1", S, LOCKED, REFEN, PERR);
        end
        nRST = 1'b0;
        #1;
        n_chk++;
        if ({S, PHI1R, LOCKED, REFEN, LONGCYC, PERR} !== 9'd0) begin
            n_err++;
            $display("FAIL mid_reset: got S=%0d L=%b RE=%b PE=%b expected all 0", S, LOCKED, REFEN, PERR);
        end
        PHI1 = 1'b0;
        @(posedge C14M);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_glitch();
        acquire();
        push_exp(1, 0, 0); phi_cycle(14, 7, -1);
        push_exp(1, 0, 0);
`ifdef RAM2E_PHI1_FILTER_EN
        phi_cycle(14, 7, 10);
        push_exp(1, 0, 0); phi_cycle(14, 7, -1);
        push_exp(1, 0, 0); phi_cycle(14, 7, -1);
`else
        push_exp(0, 0, 1);
        phi_cycle(14, 7, 10);
        push_exp(0, 0, 1); phi_cycle(14, 7, -1);
        push_exp(0, 0, 1); phi_cycle(14, 7, -1);
`endif
    endtask

    initial begin
        test_reset();
        test_lock();
        test_long();
        test_short();
        test_refresh();
        test_timeout();
        test_reset_mid();
        test_glitch();
        PHI1 = 1'b0;
        repeat (5) @(posedge C14M);
        #1;
        n_chk++;
        if (sb.size() !== 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending rises expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ram2e_phase_sync.md
Name: ram2e_phase_sync

Overview:
Upstream timing stage for the RAM2E DRAM controller.
- Samples the Apple II PHI1 clock in the C14M domain.
- Produces the 6502-cycle state counter S, a PHI1-rise strobe and a refresh-slot enable.
- Qualifies all outputs with a lock state machine that measures each 6502 cycle length: 14 C14M ticks normal, 16 stretched.
- The DRAM RAS/CAS sequencer consumes S, REFEN and LOCKED directly.

Parameters:
LOCK_COUNT, 3, number of consecutive good periods required to enter LOCK (1..7)
REF_PERIOD, 13, 6502 cycles per refresh slot (2..16)
NORM_LEN, 14, C14M ticks in a normal 6502 cycle
LONG_LEN, 16, C14M ticks in a stretched 6502 cycle
TIMEOUT, 31, C14M ticks without a PHI1 rise before lock is dropped (must exceed LONG_LEN, max 31)

Ports:
C14M  input  1  14.318 MHz master clock; all state updates on the rising edge
nRST  input  1  asynchronous active-low reset
PHI1  input  1  Apple II PHI1, asynchronous to C14M
S  output  4  state counter: 1 on PHI1 rise, then counts up, saturates at 15
PHI1R  output  1  one-C14M registered pulse marking the PHI1 rise
LOCKED  output  1  high while the FSM is in LOCK
REFEN  output  1  refresh permitted in the current 6502 cycle
LONGCYC  output  1  the period that just ended measured LONG_LEN; updated on each rise
PERR  output  1  sticky period-error flag; cleared only by reset

Behaviour:
Reset (nRST low, asynchronous):
- S=0, PHI1R=0, LOCKED=0, REFEN=0, LONGCYC=0, PERR=0.
- Internal: PHI1s=0, PHI0seen=0, C=0, Ref=0, good count=0, FSM=HUNT.

Sampling and rise detection:
- PHI1s <= PHI1 on every edge.
- PHI0seen <= 1 when PHI1 is sampled low.
- rise = PHI1 & ~PHI1s & PHI0seen. This is combinational into the next-state logic; PHI1R is its registered copy.

State counter S:
- rise: S <= 1.
- else S==0: hold at 0.
- else S==15: hold at 15.
- else: S <= S+1.
- S is not gated by LOCKED.

Period counter C (5 bits):
- rise: C <= 1.
- else: C <= C+1, saturating at 31.
- At a rise, the period is good iff C==NORM_LEN or C==LONG_LEN. The C used is the pre-update value.
- LONGCYC <= (C==LONG_LEN) on each rise.

Lock FSM:
- HUNT -> ACQ on the first rise. Good count = 0; that first period is not judged.
- ACQ, rise with good period: count+1. When count reaches LOCK_COUNT -> LOCK.
- ACQ, rise with bad period: count = 0, stay in ACQ.
- LOCK, rise with bad period: -> ACQ, count = 0, PERR <= 1.
- Any state except HUNT, when C reaches TIMEOUT with no rise: -> HUNT and clear PHI0seen. This covers a stopped or removed bus clock.

Refresh:
- Ref advances only when S==1 and LOCKED.
- Ref counts 0..REF_PERIOD-1, then wraps to 0.
- REFEN = LOCKED & (Ref==0), registered; exactly one 6502 cycle in REF_PERIOD is enabled.
- On leaving LOCK: Ref <= 0, REFEN <= 0.

Boundary cases:
- Rise and timeout on the same edge: rise wins, so the timeout does not fire.
- Reset asserted mid-cycle: all outputs return to their reset values on the next evaluation; no partial state survives.
- A PHI1 glitch shorter than one C14M period may be missed or produce a single rise. That rise then fails the period check.

Optional Feature:
Macro RAM2E_PHI1_FILTER_EN.
- Defined: PHI1 passes through a two-flop synchronizer and a 2-sample agreement filter. The filtered level changes only after two consecutive equal synchronized samples. Rise detection uses the filtered level, so S, PHI1R and C lag PHI1 by 3 C14M edges.
- Undefined: the single-sample path described above, with rise detected on the first edge that samples PHI1 high.
- Period checks, lock FSM and refresh behaviour are identical in both builds.

Test Plan:
- Reset then 6 normal PHI1 cycles (14 ticks each) -> PHI1R pulses every 14 edges; S sequence 1..14; LOCKED rises at the 4th rise (first rise plus 3 good periods); PERR=0.
- Locked, inject one 16-tick cycle -> LONGCYC=1 at the following rise, LOCKED stays 1, PERR=0. Next 14-tick cycle -> LONGCYC=0.
- Locked, inject one 12-tick cycle -> at that rise LOCKED=0 and PERR=1; LOCKED returns after 3 further good periods; PERR stays 1.
- Locked for 26 cycles -> REFEN high for exactly 2 separate 6502 cycles, 13 cycles apart.
- Hold PHI1 low 40 ticks while locked -> LOCKED=0 when C reaches 31; S saturates at 15 after 14 ticks. On restart, the first rise is not judged.
- Assert nRST during S=7 while locked -> S=0, LOCKED=0, REFEN=0, PERR=0 immediately. With RAM2E_PHI1_FILTER_EN defined, repeat test 1 -> PHI1R is 3 edges later and a 1-tick PHI1 glitch produces no rise.
